// File: rtl/encoder_pkg.sv
// Shared encoder definitions: step codes from the quadrature reader and the
// motion state encoding used by the position tracker.
package encoder_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_CCW  = 2'b01,
    DIR_CW   = 2'b10,
    DIR_ERR  = 2'b11
  } dir_code_e;

  typedef enum logic [1:0] {
    MOTION_IDLE = 2'b00,
    MOTION_CCW  = 2'b01,
    MOTION_CW   = 2'b10
  } motion_e;

  localparam int unsigned ERR_CNT_W = 8;

  // True for the two codes that represent a real shaft step.
  function automatic logic is_step(input dir_code_e code);
    return (code == DIR_CW) || (code == DIR_CCW);
  endfunction

endpackage

// File: rtl/velocity_window.sv
// Fixed-length velocity window: counts net steps over WIN_CYCLES cycles with a
// symmetric saturating accumulator and publishes the result with a valid pulse.
module velocity_window
  import encoder_pkg::*;
#(
  parameter int WIN_CYCLES = 1000,
  parameter int VEL_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    step_cw,
  input  logic                    step_ccw,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid
);

  localparam int CNT_W = $clog2(WIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic signed [VEL_W-1:0] ACC_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [VEL_W-1:0] ACC_ONE = VEL_W'(1);

  logic [CNT_W-1:0]        win_cnt;
  logic signed [VEL_W-1:0] acc;
  logic signed [VEL_W-1:0] acc_next;

  // NOTE: combinational blocks assign every output a default first so that no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    acc_next = acc;
    if (step_cw && (acc != ACC_MAX)) begin
      acc_next = acc + ACC_ONE;
    end else if (step_ccw && (acc != ACC_MIN)) begin
      acc_next = acc - ACC_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      acc       <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (clear) begin
        win_cnt <= '0;
        acc     <= '0;
      end else if (win_cnt == CNT_LAST) begin
        // The final cycle's own step is folded into the published value.
        vel       <= acc_next;
        vel_valid <= 1'b1;
        acc       <= '0;
        win_cnt   <= '0;
      end else begin
        acc     <= acc_next;
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_position_tracker.sv
// Integrates quadrature step codes into a wrapped position and revolution count,
// measures windowed velocity and classifies motion with a stall-timeout FSM.
module encoder_position_tracker
  import encoder_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int CPR          = 400,
  parameter int WIN_CYCLES   = 1000,
  parameter int VEL_W        = 12,
  parameter int STALL_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              dir,
  input  logic                    clear,
  output logic [POS_W-1:0]        pos,
  output logic [POS_W-1:0]        rev,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic [1:0]              motion,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(CPR - 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  dir_code_e code;
  logic      step_cw;
  logic      step_ccw;
  logic      idle_cycle;

  motion_e            state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  // A clear discards any step in the same cycle; that cycle then counts as idle.
  assign code       = dir_code_e'(dir);
  assign step_cw    = !clear && (code == DIR_CW);
  assign step_ccw   = !clear && (code == DIR_CCW);
  assign idle_cycle = (code == DIR_IDLE) || (clear && is_step(code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      rev <= '0;
    end else if (clear) begin
      pos <= '0;
      rev <= '0;
    end else if (step_cw) begin
      if (pos == POS_LAST) begin
        pos <= '0;
        rev <= rev + 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end else if (step_ccw) begin
      if (pos == '0) begin
        pos <= POS_LAST;
        rev <= rev - 1'b1;
      end else begin
        pos <= pos - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((code == DIR_ERR) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MOTION_IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Invalid codes fall through every branch and leave state and stall count alone.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    if (step_cw) begin
      state_d = MOTION_CW;
      stall_d = '0;
    end else if (step_ccw) begin
      state_d = MOTION_CCW;
      stall_d = '0;
    end else if (idle_cycle && (state_q != MOTION_IDLE)) begin
      if (stall_q == STALL_LAST) begin
        state_d = MOTION_IDLE;
        stall_d = '0;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  assign motion = state_q;

  velocity_window #(
    .WIN_CYCLES(WIN_CYCLES),
    .VEL_W     (VEL_W)
  ) u_velocity_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step_cw  (step_cw),
    .step_ccw (step_ccw),
    .vel      (vel),
    .vel_valid(vel_valid)
  );

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Self-checking bench for encoder_position_tracker: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_encoder_position_tracker;

  localparam int POS_W = 16;
  localparam int CPR   = 400;
  localparam int WIN   = 10;
  localparam int VEL_W = 12;
  localparam int STALL = 4;
  localparam int VMAX  = (1 << (VEL_W - 1)) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [1:0]              dir = 2'b00;
  logic                    clear = 1'b0;
  logic [POS_W-1:0]        pos;
  logic [POS_W-1:0]        rev;
  logic signed [VEL_W-1:0] vel;
  logic                    vel_valid;
  logic [1:0]              motion;
  logic [7:0]              err_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_pos, m_rev, m_acc, m_win, m_vel, m_idle, m_err;
  bit         m_vv;
  logic [1:0] m_motion;

  encoder_position_tracker #(
    .POS_W(POS_W), .CPR(CPR), .WIN_CYCLES(WIN), .VEL_W(VEL_W), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .clear(clear), .pos(pos), .rev(rev),
    .vel(vel), .vel_valid(vel_valid), .motion(motion), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_rev = 0; m_acc = 0; m_win = 0; m_vel = 0;
    m_idle = 0; m_err = 0; m_vv = 0; m_motion = 2'b00;
  endtask

  // Applies one code for one clock and advances the model; returns #1 after the edge.
  task automatic drive(input logic [1:0] d, input logic c);
    int step;
    logic [1:0] eff;
    dir = d;
    clear = c;
    @(posedge clk);
    #1;
    m_vv = 0;
    if (d == 2'b11 && m_err < 255) m_err++;
    eff = (c && (d == 2'b10 || d == 2'b01)) ? 2'b00 : d;
    step = (eff == 2'b10) ? 1 : (eff == 2'b01) ? -1 : 0;
    if (c) begin
      m_pos = 0; m_rev = 0; m_acc = 0; m_win = 0;
    end else begin
      if (step == 1) begin
        m_pos = (m_pos + 1) % CPR;
        if (m_pos == 0) m_rev++;
      end else if (step == -1) begin
        if (m_pos == 0) begin m_pos = CPR - 1; m_rev--; end
        else m_pos--;
      end
      m_acc = m_acc + step;
      if (m_acc > VMAX) m_acc = VMAX;
      if (m_acc < -VMAX) m_acc = -VMAX;
      m_win++;
      if (m_win == WIN) begin
        m_vel = m_acc; m_vv = 1; m_acc = 0; m_win = 0;
      end
    end
    if (step == 1) begin m_motion = 2'b10; m_idle = 0; end
    else if (step == -1) begin m_motion = 2'b01; m_idle = 0; end
    else if (eff == 2'b00 && m_motion != 2'b00) begin
      m_idle++;
      if (m_idle == STALL) begin m_motion = 2'b00; m_idle = 0; end
    end
  endtask

  // Reset is asserted between edges and released #1 after the held edge.
  task automatic do_reset();
    dir = 2'b00;
    clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pos !== '0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    total++; if (rev !== '0) begin bad++; $display("FAIL reset_rev got=%0d exp=0", rev); end
    total++; if (vel !== '0) begin bad++; $display("FAIL reset_vel got=%0d exp=0", vel); end
    total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL reset_vv got=%b exp=0", vel_valid); end
    total++; if (motion !== 2'b00) begin bad++; $display("FAIL reset_motion got=%b exp=00", motion); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_cw_steps();
    do_reset();
    for (int i = 0; i < 5; i++) drive(2'b10, 1'b0);
    total++; if (pos !== 16'd5) begin bad++; $display("FAIL cw_pos got=%0d exp=5", pos); end
    total++; if (rev !== 16'd0) begin bad++; $display("FAIL cw_rev got=%0d exp=0", rev); end
    total++; if (motion !== 2'b10) begin bad++; $display("FAIL cw_motion got=%b exp=10", motion); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(2'b01, 1'b0);
    total++; if (pos !== 16'd399) begin bad++; $display("FAIL wrap_ccw_pos got=%0d exp=399", pos); end
    total++; if (rev !== 16'hFFFF) begin bad++; $display("FAIL wrap_ccw_rev got=%h exp=ffff", rev); end
    drive(2'b10, 1'b0);
    total++; if (pos !== 16'd0) begin bad++; $display("FAIL wrap_cw_pos got=%0d exp=0", pos); end
    total++; if (rev !== 16'd0) begin bad++; $display("FAIL wrap_cw_rev got=%h exp=0", rev); end
  endtask

  task automatic test_velocity();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b10, 1'b0);
      total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL vel_early_vv cycle=%0d got=1 exp=0", i); end
    end
    for (int i = 0; i < 3; i++) drive(2'b01, 1'b0);
    total++; if (vel_valid !== 1'b1) begin bad++; $display("FAIL vel_vv got=%b exp=1", vel_valid); end
    total++; if (vel !== 12'sd4) begin bad++; $display("FAIL vel_value got=%0d exp=4", vel); end
    drive(2'b00, 1'b0);
    total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL vel_pulse_width got=%b exp=0", vel_valid); end
    for (int i = 0; i < WIN - 1; i++) drive(2'b00, 1'b0);
    total++; if (vel_valid !== 1'b1) begin bad++; $display("FAIL vel_idle_vv got=%b exp=1", vel_valid); end
    total++; if (vel !== 12'sd0) begin bad++; $display("FAIL vel_idle_value got=%0d exp=0", vel); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(2'b10, 1'b0);
    for (int i = 1; i <= STALL; i++) begin
      logic [1:0] exp_m;
      drive(2'b00, 1'b0);
      exp_m = (i < STALL) ? 2'b10 : 2'b00;
      total++;
      if (motion !== exp_m) begin bad++; $display("FAIL stall_idle%0d got=%b exp=%b", i, motion, exp_m); end
    end
    drive(2'b10, 1'b0);
    total++; if (motion !== 2'b10) begin bad++; $display("FAIL rev_cw got=%b exp=10", motion); end
    drive(2'b01, 1'b0);
    total++; if (motion !== 2'b01) begin bad++; $display("FAIL rev_ccw got=%b exp=01", motion); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 123; i++) drive(2'b10, 1'b0);
    total++; if (pos !== 16'd123) begin bad++; $display("FAIL clr_setup_pos got=%0d exp=123", pos); end
    drive(2'b10, 1'b1);
    total++; if (pos !== 16'd0) begin bad++; $display("FAIL clr_pos got=%0d exp=0", pos); end
    total++; if (rev !== 16'd0) begin bad++; $display("FAIL clr_rev got=%0d exp=0", rev); end
    for (int i = 1; i < WIN; i++) begin
      drive(2'b00, 1'b0);
      total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL clr_early_vv cycle=%0d got=1 exp=0", i); end
    end
    drive(2'b00, 1'b0);
    total++; if (vel_valid !== 1'b1) begin bad++; $display("FAIL clr_vv got=%b exp=1", vel_valid); end
    total++; if (vel !== 12'sd0) begin bad++; $display("FAIL clr_vel got=%0d exp=0", vel); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] d;
      logic c;
      r = int'($urandom_range(0, 99));
      if ((n % 60) >= 52) d = 2'b00;
      else if (r < 40) d = 2'b10;
      else if (r < 70) d = 2'b01;
      else if (r < 92) d = 2'b00;
      else d = 2'b11;
      c = ($urandom_range(0, 99) < 2);
      drive(d, c);
      total++; if (pos !== POS_W'(m_pos)) begin bad++; $display("FAIL rnd_pos n=%0d got=%0d exp=%0d", n, pos, m_pos); end
      total++; if (rev !== POS_W'(m_rev)) begin bad++; $display("FAIL rnd_rev n=%0d got=%h exp=%h", n, rev, POS_W'(m_rev)); end
      total++; if (vel !== VEL_W'(m_vel)) begin bad++; $display("FAIL rnd_vel n=%0d got=%0d exp=%0d", n, vel, m_vel); end
      total++; if (vel_valid !== m_vv) begin bad++; $display("FAIL rnd_vv n=%0d got=%b exp=%b", n, vel_valid, m_vv); end
      total++; if (motion !== m_motion) begin bad++; $display("FAIL rnd_motion n=%0d got=%b exp=%b", n, motion, m_motion); end
      total++; if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, err_cnt, m_err); end
    end
  endtask

  task automatic test_errors();
    logic [POS_W-1:0] pos_before;
    logic [1:0]       motion_before;
    drive(2'b01, 1'b0);
    pos_before = POS_W'(m_pos);
    motion_before = m_motion;
    for (int i = 0; i < 300; i++) drive(2'b11, 1'b0);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL err_sat got=%0d exp=255", err_cnt); end
    total++; if (pos !== pos_before) begin bad++; $display("FAIL err_pos got=%0d exp=%0d", pos, pos_before); end
    total++; if (motion !== motion_before) begin bad++; $display("FAIL err_motion got=%b exp=%b", motion, motion_before); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) drive(2'b10, 1'b0);
    drive(2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (pos !== '0) begin bad++; $display("FAIL arst_pos got=%0d exp=0", pos); end
    total++; if (rev !== '0) begin bad++; $display("FAIL arst_rev got=%0d exp=0", rev); end
    total++; if (vel !== '0) begin bad++; $display("FAIL arst_vel got=%0d exp=0", vel); end
    total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL arst_vv got=%b exp=0", vel_valid); end
    total++; if (motion !== 2'b00) begin bad++; $display("FAIL arst_motion got=%b exp=00", motion); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL arst_err got=%0d exp=0", err_cnt); end
    dir = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b10, 1'b0);
    total++; if (pos !== 16'd1) begin bad++; $display("FAIL arst_resume_pos got=%0d exp=1", pos); end
  endtask

  initial begin
    test_reset();
    test_cw_steps();
    test_wrap();
    test_velocity();
    test_stall();
    test_clear();
    test_random();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
